// File: rtl/alt_vipswi131_common_burst_read_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alt_vipswi131_common_burst_read_sequencer_pkg
//
// Shared types and helpers for the burst read sequencer:
//   state_t          - sequencer FSM encoding (IDLE/CMD/DRAIN/FIN)
//   min()            - unsigned minimum, used to size each burst
//   bytes_per_word() - address stride of one data word
//   BYTES_PER_WORD   - stride for the default 16-bit data path
// -----------------------------------------------------------------------------
package alt_vipswi131_common_burst_read_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

  // Address stride for an arbitrary data width (width is a multiple of 8).
  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Unsigned minimum on 32-bit operands; callers cast narrower counts up.
  function automatic logic [31:0] min(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/alt_vipswi131_common_burst_read_sequencer.sv
// -----------------------------------------------------------------------------
// alt_vipswi131_common_burst_read_sequencer
//
// Splits a linear read of word_count words starting at base_addr into bursts
// of at most BURST_LEN words, issues them to the bursting master, pops the
// returned words from the master's read FIFO and streams them out with a
// last flag. Command issue is credit limited: words commanded but not yet
// popped never exceed READ_FIFO_DEPTH.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   start               one-cycle job request, sampled only in IDLE
//   base_addr           byte address of the first word (sampled with start)
//   word_count          number of words to read (sampled with start)
//   busy                job in progress (CMD or DRAIN)
//   done                one-cycle completion pulse
//   addr                command address to the master
//   command             command valid
//   is_burst            follows command
//   is_write_not_read   constant 0
//   burst_length        words in the presented command
//   read                pop request to the master read FIFO
//   readdata            master read data, valid when read && !stall
//   stall               master stall; blocks both command and read
//   dout_data           stream data
//   dout_valid          stream valid
//   dout_last           marks the final word of the job
//   dout_ready          downstream accept
//   state_dbg           current FSM state, for observation only
//
// Handshakes: a command is taken on (command && !stall), a FIFO pop on
// (read && !stall), and a stream word on (dout_valid && dout_ready). Nothing
// else counts as a transfer; a held request keeps its payload stable until
// it is taken.
// -----------------------------------------------------------------------------
module alt_vipswi131_common_burst_read_sequencer
  import alt_vipswi131_common_burst_read_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH                     = 16,
  parameter int DATA_WIDTH                     = 16,
  parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
  parameter int WORDS_WIDTH                    = 24,
  parameter int BURST_LEN                      = 8,
  parameter int READ_FIFO_DEPTH                = 8
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [ADDR_WIDTH-1:0]                     base_addr,
  input  logic [WORDS_WIDTH-1:0]                    word_count,
  output logic                                      busy,
  output logic                                      done,
  output logic [ADDR_WIDTH-1:0]                     addr,
  output logic                                      command,
  output logic                                      is_burst,
  output logic                                      is_write_not_read,
  output logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] burst_length,
  output logic                                      read,
  input  logic [DATA_WIDTH-1:0]                     readdata,
  input  logic                                      stall,
  output logic [DATA_WIDTH-1:0]                     dout_data,
  output logic                                      dout_valid,
  output logic                                      dout_last,
  input  logic                                      dout_ready,
  output logic [1:0]                                state_dbg
);

  localparam int          BPW      = bytes_per_word(DATA_WIDTH);
  localparam int          OUT_W    = $clog2(READ_FIFO_DEPTH + 1);
  localparam logic [31:0] DEPTH_U  = READ_FIFO_DEPTH;
  localparam logic [31:0] BURST_U  = BURST_LEN;

  state_t                 state;
  state_t                 state_nxt;

  logic [WORDS_WIDTH-1:0] cmd_left;     // words not yet commanded
  logic [WORDS_WIDTH-1:0] pop_left;     // words not yet popped
  logic [OUT_W-1:0]       outstanding;  // commanded but not yet popped
  logic [ADDR_WIDTH-1:0]  addr_q;

  logic [DATA_WIDTH-1:0]  data_q;
  logic                   valid_q;
  logic                   last_q;

  logic [WORDS_WIDTH-1:0] len;          // size of the next burst
  logic                   credit_ok;
  logic                   cmd_take;
  logic                   pop_take;
  logic                   out_take;
  logic [OUT_W-1:0]       out_inc;
  logic [OUT_W-1:0]       out_dec;

  // ---------------------------------------------------------------------------
  // Burst sizing and credit
  // ---------------------------------------------------------------------------
  always_comb begin
    len       = WORDS_WIDTH'(min(BURST_U, 32'(cmd_left)));
    // The master FIFO must be able to absorb the whole burst on top of
    // what is already in flight, otherwise read data could be dropped.
    credit_ok = (32'(outstanding) + 32'(len)) <= DEPTH_U;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? FIN : CMD;
        end
      end
      CMD: begin
        if (cmd_take && (cmd_left == len)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Only leave once the final word has actually left the stream port.
        if ((pop_left == '0) && out_take && last_q) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and handshake qualifiers
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    command      = 1'b0;
    burst_length = '0;
    unique case (state)
      IDLE: begin
      end
      CMD: begin
        busy         = 1'b1;
        command      = credit_ok;
        burst_length = MAX_BURST_LENGTH_REQUIREDWIDTH'(len);
      end
      DRAIN: begin
        busy = 1'b1;
      end
      FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase

    is_burst          = command;
    is_write_not_read = 1'b0;

    // Pop only when the output register is free or is being emptied now,
    // so a held word is never overwritten.
    read     = (outstanding != '0) && (!valid_q || dout_ready);

    cmd_take = command && !stall;
    pop_take = read && !stall;
    out_take = valid_q && dout_ready;

    out_inc  = cmd_take ? OUT_W'(len) : '0;
    out_dec  = pop_take ? OUT_W'(1)   : '0;
  end

  // ---------------------------------------------------------------------------
  // Job counters and command address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      cmd_left    <= '0;
      pop_left    <= '0;
      outstanding <= '0;
    end else if ((state == IDLE) && start) begin
      addr_q      <= base_addr;
      cmd_left    <= word_count;
      pop_left    <= word_count;
      outstanding <= '0;
    end else begin
      if (cmd_take) begin
        // Address wraps silently at the top of the address space.
        addr_q   <= addr_q + ADDR_WIDTH'(32'(len) * BPW);
        cmd_left <= cmd_left - len;
      end
      if (pop_take) begin
        pop_left <= pop_left - WORDS_WIDTH'(1);
      end
      // Covers command-only, pop-only and the simultaneous case (+len-1).
      outstanding <= outstanding + out_inc - out_dec;
    end
  end

  // ---------------------------------------------------------------------------
  // Stream output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (pop_take) begin
      data_q  <= readdata;
      valid_q <= 1'b1;
      last_q  <= (pop_left == WORDS_WIDTH'(1));
    end else if (dout_ready) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign addr       = addr_q;
  assign dout_data  = data_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign state_dbg  = state;

  // In-flight words can never exceed what the master FIFO holds.
  credit_bound_a : assert property (@(posedge clock) disable iff (reset)
    32'(outstanding) <= DEPTH_U);

endmodule
